// File: rtl/toggle_hs_if.sv
// Bundle of the toggle-handshake receiver's data-path signals.
// slave  : the receiver (toggle_hs_rx) side.
// master : the transmitter + local consumer side driving the receiver.
//
// Handshake rules:
//   - Toggle side: the transmitter flips req_tgl once per word and holds data_in
//     stable until ack_tgl equals req_tgl again.
//   - Local side: a word transfers on every rising clk edge where dout_valid and
//     dout_ready are both 1. dout_valid never drops without such a transfer,
//     except at reset, and dout is frozen while dout_valid is 1.
interface toggle_hs_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             req_tgl;
    logic [WIDTH-1:0] data_in;
    logic             ack_tgl;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             err_overrun;
    logic             err_clr;
    logic [CNT_W-1:0] xfer_cnt;

    modport slave (
        input  req_tgl, data_in, dout_ready, err_clr,
        output ack_tgl, dout, dout_valid, err_overrun, xfer_cnt
    );

    modport master (
        output req_tgl, data_in, dout_ready, err_clr,
        input  ack_tgl, dout, dout_valid, err_overrun, xfer_cnt
    );
endinterface

// File: rtl/toggle_hs_rx.sv
// Receiving end of a two-phase (toggle) handshake.
// Synchronizes req_tgl, captures data_in on a pending request, presents the word
// on a valid/ready port and returns a toggled ack once the word is accepted.
// All outputs come straight from flops. state_o exposes the FSM (0 = IDLE, 1 = HOLD).
module toggle_hs_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    toggle_hs_if.slave  bus,
    output logic        state_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   req_p_q;
    logic [0:0]             state_q, state_d;
    logic                   ack_q, ack_d;
    logic [WIDTH-1:0]       dout_q, dout_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pending;
    logic                   overrun;

    assign req_s   = sync_q[SYNC_STAGES-1];
    // Level compare only: a request is outstanding whenever the synchronized
    // request differs from the ack we last returned.
    assign pending = (req_s != ack_q);
    // A second toggle while a word is still held means the transmitter did not
    // wait for our ack; the held word is kept and the event is only flagged.
    assign overrun = (state_q == ST_HOLD) && (req_s != req_p_q);

    // Synchronizer chain and one-cycle delayed copy of its output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            req_p_q <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_tgl};
            end else begin
                sync_q <= bus.req_tgl;
            end
            req_p_q <= req_s;
        end
    end

    // Next-state logic: capture in IDLE, hold until accepted, sticky error.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    dout_d  = bus.data_in;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.dout_ready) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Set has priority over clear when both land on the same edge.
        if (bus.err_clr) begin
            err_d = 1'b0;
        end
        if (overrun) begin
            err_d = 1'b1;
        end
    end

    // Registered FSM, data and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.ack_tgl     = ack_q;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = valid_q;
    assign bus.err_overrun = err_q;
    assign bus.xfer_cnt    = cnt_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Directed bench for toggle_hs_rx: a default instance (WIDTH 8, CNT_W 16) and a
// second instance with CNT_W 4 for the counter wrap.
module tb_toggle_hs_rx;

    logic clk;
    logic clk_run;
    logic rst;
    logic state;
    logic state4;

    int total;
    int bad;
    logic [31:0] exp_q[$];
    bit mon_en;

    toggle_hs_if #(.WIDTH(8), .CNT_W(16)) bus  ();
    toggle_hs_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

    toggle_hs_rx #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(16)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    toggle_hs_rx #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus4),
        .state_o (state4)
    );

    // Clock / reset block: clock can be parked low to show reset is asynchronous.
    initial begin
        clk = 1'b0;
        clk_run = 1'b0;
        rst = 1'b1;
    end
    always #5 clk = clk_run ? ~clk : clk;

    // Scoreboard check.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait for ack_tgl to match req_tgl on the selected instance.
    task automatic wait_ack(input int which, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            tick(1);
            if (which == 0) done = (bus.ack_tgl == bus.req_tgl);
            else            done = (bus4.ack_tgl == bus4.req_tgl);
        end
        if (!done) check(tag, 32'd0, 32'd1);
    endtask

    // Behavioral toggle transmitter for the default instance.
    task automatic send_word(input logic [7:0] d);
        bus.data_in = d;
        bus.req_tgl = ~bus.req_tgl;
        wait_ack(0, "seq_ack_timeout");
    endtask

    // Consumer-side monitor: a word seen valid with ready high transfers at the next edge.
    always @(negedge clk) begin
        if (mon_en && bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) check("seq_extra_word", {24'd0, bus.dout}, 32'hffff_ffff);
            else                   check("seq_dout", {24'd0, bus.dout}, exp_q.pop_front());
        end
    end

    initial begin
        total = 0;
        bad = 0;
        mon_en = 1'b0;

        // ---- Reset values, clock stopped, random inputs ----
        bus.data_in = 8'($urandom);
        bus.req_tgl = 1'($urandom_range(0, 1));
        bus.dout_ready = 1'($urandom_range(0, 1));
        bus.err_clr = 1'($urandom_range(0, 1));
        bus4.data_in = 8'($urandom);
        bus4.req_tgl = 1'($urandom_range(0, 1));
        bus4.dout_ready = 1'($urandom_range(0, 1));
        bus4.err_clr = 1'b0;
        #3;
        check("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
        check("rst_dout", {24'd0, bus.dout}, 32'd0);
        check("rst_ack", {31'd0, bus.ack_tgl}, 32'd0);
        check("rst_err", {31'd0, bus.err_overrun}, 32'd0);
        check("rst_cnt", {16'd0, bus.xfer_cnt}, 32'd0);
        check("rst_state", {31'd0, state}, 32'd0);
        clk_run = 1'b1;
        tick(2);
        check("rst_clk_valid", {31'd0, bus.dout_valid}, 32'd0);
        check("rst_clk_ack", {31'd0, bus.ack_tgl}, 32'd0);
        bus.data_in = 8'h00; bus.req_tgl = 1'b0; bus.dout_ready = 1'b0; bus.err_clr = 1'b0;
        bus4.data_in = 8'h00; bus4.req_tgl = 1'b0; bus4.dout_ready = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);

        // ---- Single word A5 ----
        bus.dout_ready = 1'b1;
        bus.data_in = 8'hA5;
        bus.req_tgl = 1'b1;
        tick(1);
        check("single_valid_e0", {31'd0, bus.dout_valid}, 32'd0);
        tick(1);
        check("single_valid_e1", {31'd0, bus.dout_valid}, 32'd0);
        tick(1);
        check("single_valid_e2", {31'd0, bus.dout_valid}, 32'd1);
        check("single_dout", {24'd0, bus.dout}, 32'hA5);
        check("single_ack_before", {31'd0, bus.ack_tgl}, 32'd0);
        check("single_state_hold", {31'd0, state}, 32'd1);
        tick(1);
        check("single_valid_after", {31'd0, bus.dout_valid}, 32'd0);
        check("single_ack_after", {31'd0, bus.ack_tgl}, 32'd1);
        check("single_cnt", {16'd0, bus.xfer_cnt}, 32'd1);

        // ---- Backpressure with 3C ----
        bus.dout_ready = 1'b0;
        bus.data_in = 8'h3C;
        bus.req_tgl = 1'b0;
        tick(3);
        check("bp_valid", {31'd0, bus.dout_valid}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("bp_hold_valid", {31'd0, bus.dout_valid}, 32'd1);
            check("bp_hold_dout", {24'd0, bus.dout}, 32'h3C);
            check("bp_hold_ack", {31'd0, bus.ack_tgl}, 32'd1);
        end
        bus.dout_ready = 1'b1;
        tick(1);
        check("bp_accept_valid", {31'd0, bus.dout_valid}, 32'd0);
        check("bp_accept_ack", {31'd0, bus.ack_tgl}, 32'd0);
        check("bp_accept_cnt", {16'd0, bus.xfer_cnt}, 32'd2);
        bus.dout_ready = 1'b0;
        tick(2);
        check("no_back_to_back", {31'd0, bus.dout_valid}, 32'd0);

        // ---- Overrun ----
        bus.data_in = 8'h77;
        bus.req_tgl = 1'b1;
        tick(3);
        check("ovr_capture", {24'd0, bus.dout}, 32'h77);
        check("ovr_err_before", {31'd0, bus.err_overrun}, 32'd0);
        bus.data_in = 8'h88;
        bus.req_tgl = 1'b0;
        tick(3);
        check("ovr_err_set", {31'd0, bus.err_overrun}, 32'd1);
        check("ovr_dout_kept", {24'd0, bus.dout}, 32'h77);
        check("ovr_valid_kept", {31'd0, bus.dout_valid}, 32'd1);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        check("ovr_err_clr", {31'd0, bus.err_overrun}, 32'd0);
        bus.req_tgl = 1'b1;
        tick(2);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        check("ovr_set_beats_clr", {31'd0, bus.err_overrun}, 32'd1);
        tick(1);
        check("ovr_sticky", {31'd0, bus.err_overrun}, 32'd1);
        check("ovr_dout_final", {24'd0, bus.dout}, 32'h77);

        // ---- Reset mid-HOLD with req_tgl = 1 ----
        check("mid_hold_state", {31'd0, state}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, bus.dout_valid}, 32'd0);
        check("mid_rst_ack", {31'd0, bus.ack_tgl}, 32'd0);
        check("mid_rst_err", {31'd0, bus.err_overrun}, 32'd0);
        check("mid_rst_cnt", {16'd0, bus.xfer_cnt}, 32'd0);
        bus.data_in = 8'h55;
        tick(1);
        rst = 1'b0;
        tick(2);
        check("mid_rel_valid_e1", {31'd0, bus.dout_valid}, 32'd0);
        tick(1);
        check("mid_rel_valid_e2", {31'd0, bus.dout_valid}, 32'd1);
        check("mid_rel_dout", {24'd0, bus.dout}, 32'h55);

        // ---- Fresh reset, then 5-word sequence ----
        bus.req_tgl = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        bus.dout_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(32'(i));
            send_word(8'(i));
        end
        tick(2);
        mon_en = 1'b0;
        check("seq_all_seen", 32'(exp_q.size()), 32'd0);
        check("seq_cnt", {16'd0, bus.xfer_cnt}, 32'd5);
        check("seq_ack", {31'd0, bus.ack_tgl}, 32'd1);
        check("seq_err", {31'd0, bus.err_overrun}, 32'd0);

        // ---- Counter wrap on the CNT_W = 4 instance ----
        bus4.dout_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            bus4.data_in = 8'(i);
            bus4.req_tgl = ~bus4.req_tgl;
            wait_ack(1, "wrap_ack_timeout");
            if (i == 16) check("wrap_cnt_16", {28'd0, bus4.xfer_cnt}, 32'd0);
        end
        tick(1);
        check("wrap_cnt_17", {28'd0, bus4.xfer_cnt}, 32'd1);
        check("wrap_err", {31'd0, bus4.err_overrun}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
